// File: rtl/ysyx_24090018_pkg.sv
// Shared types and widths for the writeback port arbiter.
package ysyx_24090018_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_EXU  = 2'b01,
    GNT_LSU  = 2'b10
  } grant_t;

endpackage

// File: rtl/ysyx_24090018_wb_arb_core.sv
// LSU-first grant with an EXU starvation counter that forces an EXU win
// once the EXU has lost STARVE_LIMIT consecutive cycles.
module ysyx_24090018_wb_arb_core
  import ysyx_24090018_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exu_valid,
  input  logic                 lsu_valid,
  output grant_t               grant,
  output logic [CNT_WIDTH-1:0] starve_cnt
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starve_cnt_reg;
  logic [CNT_WIDTH-1:0] starve_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_reg <= '0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

  // Grant depends only on valids and the counter, never on payloads.
  always_comb begin
    grant           = GNT_NONE;
    starve_cnt_next = '0;
    if (!rst) begin
      if (exu_valid && lsu_valid)
        grant = (starve_cnt_reg == LIMIT) ? GNT_EXU : GNT_LSU;
      else if (exu_valid)
        grant = GNT_EXU;
      else if (lsu_valid)
        grant = GNT_LSU;
    end
    if (exu_valid && grant != GNT_EXU)
      starve_cnt_next = (starve_cnt_reg == LIMIT) ? starve_cnt_reg
                                                  : starve_cnt_reg + 1'b1;
  end

  assign starve_cnt = starve_cnt_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the regfile write port between EXU and LSU results.
// Optional perf counters: define YSYX_24090018_WB_ARB_PERF_EN.
module wb_port_arbiter
  import ysyx_24090018_pkg::*;
#(
  parameter int DATA_WIDTH   = ysyx_24090018_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = ysyx_24090018_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid_i,
  output logic                  exu_ready_o,
  input  logic [ADDR_WIDTH-1:0] exu_rd_i,
  input  logic [DATA_WIDTH-1:0] exu_data_i,
  input  logic                  exu_wen_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  rf_wen_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [3:0]            starve_cnt_o
`ifdef YSYX_24090018_WB_ARB_PERF_EN
  ,
  output logic [31:0]           perf_exu_cnt_o,
  output logic [31:0]           perf_lsu_cnt_o,
  output logic [31:0]           perf_conflict_cnt_o
`endif
);

  grant_t grant;

  logic                  rf_wen_reg;
  logic [ADDR_WIDTH-1:0] rf_waddr_reg;
  logic [DATA_WIDTH-1:0] rf_wdata_reg;

  ysyx_24090018_wb_arb_core #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .exu_valid  (exu_valid_i),
    .lsu_valid  (lsu_valid_i),
    .grant      (grant),
    .starve_cnt (starve_cnt_o)
  );

  assign exu_ready_o = (grant == GNT_EXU);
  assign lsu_ready_o = (grant == GNT_LSU);

  // Address/data follow write-capable results only, so an EXU result with
  // wen=0 (store/branch) leaves the last written address/data visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_wen_reg <= 1'b0;
      case (grant)
        GNT_EXU: begin
          rf_wen_reg <= exu_wen_i && (exu_rd_i != '0);
          if (exu_wen_i) begin
            rf_waddr_reg <= exu_rd_i;
            rf_wdata_reg <= exu_data_i;
          end
        end
        GNT_LSU: begin
          rf_wen_reg   <= (lsu_rd_i != '0);
          rf_waddr_reg <= lsu_rd_i;
          rf_wdata_reg <= lsu_data_i;
        end
        default: ;
      endcase
    end
  end

  assign rf_wen_o   = rf_wen_reg;
  assign rf_waddr_o = rf_waddr_reg;
  assign rf_wdata_o = rf_wdata_reg;

`ifdef YSYX_24090018_WB_ARB_PERF_EN
  logic [31:0] perf_exu_reg;
  logic [31:0] perf_lsu_reg;
  logic [31:0] perf_conflict_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_exu_reg      <= '0;
      perf_lsu_reg      <= '0;
      perf_conflict_reg <= '0;
    end else begin
      if (grant == GNT_EXU)          perf_exu_reg      <= perf_exu_reg + 32'd1;
      if (grant == GNT_LSU)          perf_lsu_reg      <= perf_lsu_reg + 32'd1;
      if (exu_valid_i && lsu_valid_i) perf_conflict_reg <= perf_conflict_reg + 32'd1;
    end
  end

  assign perf_exu_cnt_o      = perf_exu_reg;
  assign perf_lsu_cnt_o      = perf_lsu_reg;
  assign perf_conflict_cnt_o = perf_conflict_reg;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a behavioural
// model of the grant/starvation/writeback rules.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev = 1'b0, ewen = 1'b0, lv = 1'b0;
  logic [AW-1:0] erd = '0, lrd = '0;
  logic [DW-1:0] edata = '0, ldata = '0;

  logic          exu_ready_o, lsu_ready_o, rf_wen_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [3:0]    starve_cnt_o;
`ifdef YSYX_24090018_WB_ARB_PERF_EN
  logic [31:0]   perf_exu_cnt_o, perf_lsu_cnt_o, perf_conflict_cnt_o;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .exu_valid_i  (ev),
    .exu_ready_o  (exu_ready_o),
    .exu_rd_i     (erd),
    .exu_data_i   (edata),
    .exu_wen_i    (ewen),
    .lsu_valid_i  (lv),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (lrd),
    .lsu_data_i   (ldata),
    .rf_wen_o     (rf_wen_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .starve_cnt_o (starve_cnt_o)
`ifdef YSYX_24090018_WB_ARB_PERF_EN
    ,
    .perf_exu_cnt_o      (perf_exu_cnt_o),
    .perf_lsu_cnt_o      (perf_lsu_cnt_o),
    .perf_conflict_cnt_o (perf_conflict_cnt_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: consecutive EXU losses, last grant, expected write port.
  int            m_losses;
  int            m_last;      // 0 none, 1 exu, 2 lsu
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  function automatic int exp_grant();
    if (ev && lv) return (m_losses == LIMIT) ? 1 : 2;
    if (ev) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] rdy_of(int g);
    return (g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_reset();
    m_losses = 0; m_last = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // Advance one clock (called just after a negedge) and update the model.
  task automatic tick();
    int g;
    g = exp_grant();
    @(posedge clk);
    m_last = g;
    m_wen  = 1'b0;
    if (g == 1) begin
      m_wen = ewen && (erd != 0);
      if (ewen) begin m_waddr = erd; m_wdata = edata; end
      m_losses = 0;
    end else if (g == 2) begin
      m_wen = (lrd != 0); m_waddr = lrd; m_wdata = ldata;
      m_losses = ev ? ((m_losses < LIMIT) ? m_losses + 1 : LIMIT) : 0;
    end else begin
      m_losses = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({rf_wen_o, rf_waddr_o, rf_wdata_o, starve_cnt_o} !== '0) begin
      n_err++; $display("FAIL reset_init: got wen=%b addr=%0d data=%h cnt=%0d, want all 0",
                        rf_wen_o, rf_waddr_o, rf_wdata_o, starve_cnt_o);
    end
    rst = 1'b0; model_reset();
    ev = 1; erd = 3; edata = 32'h11; ewen = 1; lv = 1; lrd = 9; ldata = 32'h22;
    tick(); lrd = 10; tick();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({rf_wen_o, exu_ready_o, lsu_ready_o, starve_cnt_o} !== 7'd0) begin
      n_err++; $display("FAIL reset_mid: got wen=%b erdy=%b lrdy=%b cnt=%0d, want 0 0 0 0",
                        rf_wen_o, exu_ready_o, lsu_ready_o, starve_cnt_o);
    end
    @(negedge clk);
    n_vec++;
    if (rf_wen_o !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: rf_wen got %b want 0", rf_wen_o);
    end
    ev = 0; lv = 0; rst = 1'b0; model_reset();
    tick();
    n_vec++;
    if (rf_wen_o !== 1'b0) begin
      n_err++; $display("FAIL reset_release: rf_wen got %b want 0", rf_wen_o);
    end
    $display("reset: checked init, mid-run assert, release");
  endtask

  task automatic test_exu_only();
    ev = 1; erd = 5; edata = 32'h1234; ewen = 1; lv = 0;
    #1;
    n_vec++;
    if ({lsu_ready_o, exu_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL exu_only_ready: got lrdy/erdy=%b want 01", {lsu_ready_o, exu_ready_o});
    end
    tick(); ev = 0;
    n_vec++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234) begin
      n_err++; $display("FAIL exu_only_write: got wen=%b addr=%0d data=%h want 1 5 00001234",
                        rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    $display("exu_only: rd=5 data=00001234");
  endtask

  task automatic test_conflict();
    ev = 0; lv = 0; tick();
    for (int i = 0; i < 6; i++) begin
      ev = 1; erd = 12; edata = 32'hE0 + i; ewen = 1;
      lv = 1; lrd = AW'(13 + i); ldata = $urandom;
      #1;
      n_vec++;
      if ({lsu_ready_o, exu_ready_o} !== ((i == 4) ? 2'b01 : 2'b10) ||
          starve_cnt_o !== ((i <= 4) ? 4'(i) : 4'd0)) begin
        n_err++; $display("FAIL conflict_c%0d: got lrdy/erdy=%b cnt=%0d want %b cnt=%0d", i,
                          {lsu_ready_o, exu_ready_o}, starve_cnt_o,
                          (i == 4) ? 2'b01 : 2'b10, (i <= 4) ? i : 0);
      end
      tick();
      $display("conflict: cycle %0d granted %s", i, (m_last == 1) ? "EXU" : "LSU");
    end
    ev = 0; lv = 0;
  endtask

  task automatic test_x0();
    lv = 1; lrd = 0; ldata = 32'hDEADBEEF; ev = 0;
    #1;
    n_vec++;
    if (lsu_ready_o !== 1'b1) begin
      n_err++; $display("FAIL x0_ready: lsu_ready got %b want 1", lsu_ready_o);
    end
    tick(); lv = 0;
    n_vec++;
    if (rf_wen_o !== 1'b0) begin
      n_err++; $display("FAIL x0_write: rf_wen got %b want 0", rf_wen_o);
    end
    $display("x0: load to rd=0 suppressed");
  endtask

  task automatic test_no_write();
    logic [AW-1:0] old_addr;
    logic [DW-1:0] old_data;
    ev = 1; lv = 0; lrd = 8; ldata = 32'h5A5A0001; lv = 1; tick();   // establish a known write
    lv = 0; tick();                                                  // EXU drains, same payload
    old_addr = rf_waddr_o === erd ? erd : m_waddr;
    old_addr = m_waddr; old_data = m_wdata;
    ev = 1; erd = 7; edata = 32'hCAFE0007; ewen = 0;
    #1;
    n_vec++;
    if (exu_ready_o !== 1'b1) begin
      n_err++; $display("FAIL nowrite_ready: exu_ready got %b want 1", exu_ready_o);
    end
    tick(); ev = 0;
    n_vec++;
    if (rf_wen_o !== 1'b0 || rf_waddr_o !== old_addr || rf_wdata_o !== old_data) begin
      n_err++; $display("FAIL nowrite_hold: got wen=%b addr=%0d data=%h want 0 %0d %h",
                        rf_wen_o, rf_waddr_o, rf_wdata_o, old_addr, old_data);
    end
    $display("no_write: rd=7 wen=0 leaves port at addr=%0d", old_addr);
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 300; n++) begin
      if (!(ev && m_last != 1) || n == 0) begin
        ev = ($urandom_range(0, 3) != 0); erd = AW'($urandom); edata = $urandom;
        ewen = ($urandom_range(0, 3) != 0);
      end
      if (!(lv && m_last != 2) || n == 0) begin
        lv = ($urandom_range(0, 2) != 0); lrd = AW'($urandom); ldata = $urandom;
      end
      #1;
      g = exp_grant();
      n_vec++;
      if ({lsu_ready_o, exu_ready_o} !== rdy_of(g) || starve_cnt_o !== 4'(m_losses)) begin
        n_err++; $display("FAIL rand_grant[%0d]: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", n,
                          {lsu_ready_o, exu_ready_o}, starve_cnt_o, rdy_of(g), m_losses);
      end
      tick();
      n_vec++;
      if (rf_wen_o !== m_wen || rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata) begin
        n_err++; $display("FAIL rand_write[%0d]: got wen=%b addr=%0d data=%h want %b %0d %h", n,
                          rf_wen_o, rf_waddr_o, rf_wdata_o, m_wen, m_waddr, m_wdata);
      end
      $display("rand %0d: ev=%b lv=%b grant=%0d wen=%b addr=%0d", n, ev, lv, g, m_wen, m_waddr);
    end
    ev = 0; lv = 0;
  endtask

`ifdef YSYX_24090018_WB_ARB_PERF_EN
  task automatic test_perf();
    ev = 0; lv = 0;
    #2 rst = 1'b1;
    #1 rst = 1'b0; model_reset();
    @(negedge clk);
    ev = 1; erd = 4; edata = 32'h44; ewen = 1; lv = 1; lrd = 6; ldata = 32'h66;
    tick(); lrd = 7; tick();
    lv = 0; tick(); erd = 5; tick(); erd = 6; tick();
    ev = 0;
    #1;
    n_vec++;
    if (perf_exu_cnt_o !== 32'd3 || perf_lsu_cnt_o !== 32'd2 || perf_conflict_cnt_o !== 32'd2) begin
      n_err++; $display("FAIL perf: got exu=%0d lsu=%0d conflict=%0d want 3 2 2",
                        perf_exu_cnt_o, perf_lsu_cnt_o, perf_conflict_cnt_o);
    end
    $display("perf: exu=%0d lsu=%0d conflict=%0d", perf_exu_cnt_o, perf_lsu_cnt_o,
             perf_conflict_cnt_o);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_exu_only();
    test_conflict();
    test_x0();
    test_no_write();
    test_random();
`ifdef YSYX_24090018_WB_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
